entry_park_allocator: RTL and testbench

Entry-side counterpart of the exit path. On a car arrival, the block allocates the lowest-numbered free slot in an 8-slot lot, marks it occupied, and issues an encrypted 3-bit token to the gate display over a valid/ready handshake. It also consumes the one-hot park_location produced by the exit path, so that vacated slots are freed. It owns the lot occupancy register for the whole design.

---
 rtl/park_pkg.sv | 19 +
 rtl/lowest_free_encoder.sv | 23 ++
 rtl/entry_park_allocator.sv | 106 ++++++++++
 tb/tb_entry_park_allocator.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/park_pkg.sv
// Shared constants, FSM state type and token cipher for the parking lot entry/exit paths.
// encrypt_idx is also the exit-side decrypt, since XOR with the same pattern round-trips.
package park_pkg;

  localparam int IDX_W     = 3;
  localparam int NUM_SLOTS = 8;

  typedef enum logic [1:0] {
    IDLE,
    ALLOC,
    ISSUE
  } state_t;

  function automatic logic [IDX_W-1:0] encrypt_idx(input logic [IDX_W-1:0] idx,
                                                   input logic [IDX_W-1:0] pattern);
    return idx ^ pattern;
  endfunction

endpackage

// File: rtl/lowest_free_encoder.sv
// Combinational priority encoder: index of the lowest clear bit in the occupancy map.
// any_free is low only when every slot is taken; idx is then 0 and must be ignored.
module lowest_free_encoder
  import park_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] occupancy,
  output logic [IDX_W-1:0]     idx,
  output logic                 any_free
);

  // Scan downwards so the last hit, and therefore the winner, is the lowest free slot.
  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        idx      = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/entry_park_allocator.sv
// Entry-side slot allocator: hands out the lowest free slot as an encrypted token and
// owns the lot occupancy map, which the exit path frees through exit_location.
module entry_park_allocator
  import park_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enter,
  input  logic [IDX_W-1:0]     pattern,
  input  logic                 exit_valid,
  input  logic [NUM_SLOTS-1:0] exit_location,
  output logic [IDX_W-1:0]     token,
  output logic                 token_valid,
  input  logic                 token_ready,
  output logic                 reject,
  output logic                 exit_err,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [IDX_W:0]       free_count,
  output logic                 full
);

  state_t               state;
  logic [IDX_W-1:0]     pattern_q;
  logic [IDX_W-1:0]     free_idx;
  logic                 any_free;
  logic                 exit_onehot;
  logic                 exit_hit;
  logic                 exit_bad;
  logic                 do_alloc;
  logic [NUM_SLOTS-1:0] occ_next;
  logic [IDX_W:0]       free_next;

  lowest_free_encoder u_lowest_free (
    .occupancy (occupancy),
    .idx       (free_idx),
    .any_free  (any_free)
  );

  // Exit decisions look only at the pre-edge map, so they never see this cycle's allocation.
  assign exit_onehot = (exit_location != '0) &&
                       ((exit_location & (exit_location - NUM_SLOTS'(1))) == '0);
  assign exit_hit    = exit_valid && exit_onehot && ((occupancy & exit_location) != '0);
  assign exit_bad    = exit_valid && !exit_hit;
  assign do_alloc    = (state == ALLOC) && any_free;

  always_comb begin
    occ_next = occupancy;
    if (do_alloc) begin
      occ_next[free_idx] = 1'b1;
    end
    if (exit_hit) begin
      occ_next = occ_next & ~exit_location;
    end
    free_next = (IDX_W + 1)'(NUM_SLOTS);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_next = free_next - {{IDX_W{1'b0}}, occ_next[i]};
    end
  end

  // free_count and full track the new occupancy on the same edge, so they never lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pattern_q   <= '0;
      token       <= '0;
      token_valid <= 1'b0;
      reject      <= 1'b0;
      exit_err    <= 1'b0;
      occupancy   <= '0;
      free_count  <= (IDX_W + 1)'(NUM_SLOTS);
      full        <= 1'b0;
    end else begin
      occupancy  <= occ_next;
      free_count <= free_next;
      full       <= &occ_next;
      reject     <= 1'b0;
      exit_err   <= exit_bad;
      case (state)
        IDLE: begin
          if (enter) begin
            pattern_q <= pattern;
            state     <= ALLOC;
          end
        end
        ALLOC: begin
          if (!any_free) begin
            reject <= 1'b1;
            state  <= IDLE;
          end else begin
            token       <= encrypt_idx(free_idx, pattern_q);
            token_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (token_ready) begin
            token_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_entry_park_allocator.sv
// Randomized self-checking bench for entry_park_allocator against a slot-array model
// of the lot: lowest free slot wins, exits free only occupied one-hot slots.
module tb_entry_park_allocator;
  import park_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 enter;
  logic [IDX_W-1:0]     pattern;
  logic                 exit_valid;
  logic [NUM_SLOTS-1:0] exit_location;
  logic [IDX_W-1:0]     token;
  logic                 token_valid;
  logic                 token_ready;
  logic                 reject;
  logic                 exit_err;
  logic [NUM_SLOTS-1:0] occupancy;
  logic [IDX_W:0]       free_count;
  logic                 full;

  int vectors;
  int miscompares;
  bit m_occ [NUM_SLOTS];

  entry_park_allocator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enter         (enter),
    .pattern       (pattern),
    .exit_valid    (exit_valid),
    .exit_location (exit_location),
    .token         (token),
    .token_valid   (token_valid),
    .token_ready   (token_ready),
    .reject        (reject),
    .exit_err      (exit_err),
    .occupancy     (occupancy),
    .free_count    (free_count),
    .full          (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NUM_SLOTS-1:0] m_vec();
    logic [NUM_SLOTS-1:0] v;
    for (int i = 0; i < NUM_SLOTS; i++) v[i] = m_occ[i];
    return v;
  endfunction

  function automatic int m_free();
    int n = NUM_SLOTS;
    for (int i = 0; i < NUM_SLOTS; i++) if (m_occ[i]) n = n - 1;
    return n;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < NUM_SLOTS; i++) if (!m_occ[i]) return i;
    return -1;
  endfunction

  function automatic bit m_exit(input logic [NUM_SLOTS-1:0] loc);
    int ones = 0;
    int j = 0;
    for (int i = 0; i < NUM_SLOTS; i++) if (loc[i]) begin ones++; j = i; end
    if (ones != 1) return 1'b1;
    if (!m_occ[j]) return 1'b1;
    m_occ[j] = 1'b0;
    return 1'b0;
  endfunction

  task automatic applyStimulus(input logic en, input logic [IDX_W-1:0] pat,
                               input logic ev, input logic [NUM_SLOTS-1:0] loc);
    enter         = en;
    pattern       = pat;
    exit_valid    = ev;
    exit_location = loc;
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, '0, 1'b0, '0);
    token_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_SLOTS; i++) m_occ[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic alloc_txn(input logic [IDX_W-1:0] pat, input int stall,
                           input bit exit_in_alloc, input logic [NUM_SLOTS-1:0] exit_loc);
    int slot;
    bit exp_err;
    logic [IDX_W-1:0] exp_tok;
    slot = m_lowest();
    applyStimulus(1'b1, pat, 1'b0, '0);
    @(negedge clk);
    applyStimulus(1'($urandom), 3'($urandom), exit_in_alloc, exit_loc);
    exp_err = exit_in_alloc ? m_exit(exit_loc) : 1'b0;
    if (slot >= 0) m_occ[slot] = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0, '0);
    vectors++;
    if (exit_err !== exp_err) begin
      miscompares++;
      $display("[TB] FAIL alloc_exit_err: got %b expected %b", exit_err, exp_err);
    end
    vectors++;
    if (occupancy !== m_vec() || free_count !== (IDX_W+1)'(m_free()) || full !== (m_free() == 0)) begin
      miscompares++;
      $display("[TB] FAIL alloc_occ: got occ=%h free=%0d full=%b expected occ=%h free=%0d full=%b",
               occupancy, free_count, full, m_vec(), m_free(), m_free() == 0);
    end
    if (slot < 0) begin
      vectors++;
      if (reject !== 1'b1 || token_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reject_pulse: got reject=%b valid=%b expected reject=1 valid=0", reject, token_valid);
      end
      @(negedge clk);
      vectors++;
      if (reject !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reject_width: got %b expected 0", reject);
      end
      return;
    end
    exp_tok = 3'(slot) ^ pat;
    vectors++;
    if (token_valid !== 1'b1 || token !== exp_tok || reject !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL token_issue: got valid=%b token=%h reject=%b expected valid=1 token=%h reject=0",
               token_valid, token, reject, exp_tok);
    end
    for (int s = 0; s < stall; s++) begin
      applyStimulus(1'($urandom), 3'($urandom), 1'b0, '0);
      @(negedge clk);
      vectors++;
      if (token_valid !== 1'b1 || token !== exp_tok || occupancy !== m_vec()) begin
        miscompares++;
        $display("[TB] FAIL stall_hold: got valid=%b token=%h occ=%h expected valid=1 token=%h occ=%h",
                 token_valid, token, occupancy, exp_tok, m_vec());
      end
    end
    applyStimulus(1'b0, '0, 1'b0, '0);
    token_ready = 1'b1;
    @(negedge clk);
    token_ready = 1'b0;
    vectors++;
    if (token_valid !== 1'b0 || occupancy !== m_vec()) begin
      miscompares++;
      $display("[TB] FAIL handshake_done: got valid=%b occ=%h expected valid=0 occ=%h",
               token_valid, occupancy, m_vec());
    end
  endtask

  task automatic exit_txn(input logic [NUM_SLOTS-1:0] loc);
    bit exp_err;
    applyStimulus(1'b0, '0, 1'b1, loc);
    exp_err = m_exit(loc);
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0, '0);
    vectors++;
    if (exit_err !== exp_err || occupancy !== m_vec() || free_count !== (IDX_W+1)'(m_free())) begin
      miscompares++;
      $display("[TB] FAIL exit_%h: got err=%b occ=%h free=%0d expected err=%b occ=%h free=%0d",
               loc, exit_err, occupancy, free_count, exp_err, m_vec(), m_free());
    end
    @(negedge clk);
    vectors++;
    if (exit_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL exit_err_width: got %b expected 0", exit_err);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (occupancy !== 8'h00 || free_count !== 4'd8 || full !== 1'b0 || token !== 3'd0 ||
        token_valid !== 1'b0 || reject !== 1'b0 || exit_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got occ=%h free=%0d full=%b token=%h valid=%b reject=%b err=%b expected 00/8/0/0/0/0/0",
               occupancy, free_count, full, token, token_valid, reject, exit_err);
    end
  endtask

  task automatic test_first_alloc();
    alloc_txn(3'b101, 0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < NUM_SLOTS; k++) alloc_txn(3'b000, 0, 1'b0, '0);
    alloc_txn(3'b000, 0, 1'b0, '0);
  endtask

  task automatic test_stall();
    do_reset();
    alloc_txn(3'($urandom), 5, 1'b0, '0);
  endtask

  task automatic test_exit_free();
    do_reset();
    for (int k = 0; k < 4; k++) alloc_txn(3'($urandom), 0, 1'b0, '0);
    exit_txn(8'h04);
    alloc_txn(3'b110, 0, 1'b0, '0);
  endtask

  task automatic test_exit_errors();
    exit_txn(8'h06);
    exit_txn(8'h80);
    exit_txn(8'h00);
  endtask

  task automatic test_full_exit_alloc();
    do_reset();
    for (int k = 0; k < NUM_SLOTS; k++) alloc_txn(3'($urandom), 0, 1'b0, '0);
    alloc_txn(3'b011, 0, 1'b1, 8'h08);
  endtask

  task automatic test_reset_in_issue();
    applyStimulus(1'b1, 3'b010, 1'b0, '0);
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NUM_SLOTS; i++) m_occ[i] = 1'b0;
    vectors++;
    if (token_valid !== 1'b0 || occupancy !== 8'h00 || free_count !== 4'd8 || full !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_in_issue: got valid=%b occ=%h free=%0d full=%b expected 0/00/8/0",
               token_valid, occupancy, free_count, full);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [NUM_SLOTS-1:0] loc;
    int occ_idx;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(3, 0))
        0, 1: begin
          if ($urandom_range(1, 0) == 1) begin
            loc = NUM_SLOTS'(1) << $urandom_range(NUM_SLOTS - 1, 0);
            alloc_txn(3'($urandom), $urandom_range(3, 0), 1'b1, loc);
          end else begin
            alloc_txn(3'($urandom), $urandom_range(3, 0), 1'b0, '0);
          end
        end
        2: begin
          occ_idx = $urandom_range(NUM_SLOTS - 1, 0);
          exit_txn(NUM_SLOTS'(1) << occ_idx);
        end
        default: exit_txn(8'($urandom));
      endcase
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    token_ready = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    $display("[TB] entry_park_allocator bench starting");
    test_reset();
    test_first_alloc();
    test_back_to_back();
    test_stall();
    test_exit_free();
    test_exit_errors();
    test_full_exit_alloc();
    test_reset_in_issue();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
